// File: rtl/sensor_adc_sequencer.sv
// Power / settle / read / convert sequencer between the adapter and the sens_*/adc_* pins.
// Optional: define SENSOR_ADC_SEQ_OVERSAMPLE_EN to average four conversions per measurement.
module sensor_adc_sequencer #(
  parameter int SETTLE_TICKS  = 64,
  parameter int READ_TICKS    = 4,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  config_in,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] result,
  output logic [2:0]  sens_config,
  output logic        sens_enable,
  output logic        sens_read,
  output logic        adc_enable,
  output logic        adc_read,
  input  logic        adc_conversion_complete,
  input  logic [15:0] adc_value
);

  localparam int MAX_SR = (SETTLE_TICKS > READ_TICKS) ? SETTLE_TICKS : READ_TICKS;
  localparam int MAX_P  = (MAX_SR > TIMEOUT_TICKS) ? MAX_SR : TIMEOUT_TICKS;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE_TICKS);
  localparam logic [CW-1:0] READ_C    = CW'(READ_TICKS);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {IDLE, POWER_UP, SAMPLE, CONVERT} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [15:0]   result_next;
  logic [2:0]    config_next;
  logic          done_next, timeout_next;

`ifdef SENSOR_ADC_SEQ_OVERSAMPLE_EN
  logic [17:0] acc, acc_next, sum;
  logic [1:0]  round, round_next;
`endif

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    result_next  = result;
    config_next  = sens_config;
    done_next    = 1'b0;
    timeout_next = 1'b0;
`ifdef SENSOR_ADC_SEQ_OVERSAMPLE_EN
    acc_next   = acc;
    round_next = round;
    sum        = acc + {2'b00, adc_value};
`endif
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_next  = POWER_UP;
          cnt_next    = ONE;
          config_next = config_in;
`ifdef SENSOR_ADC_SEQ_OVERSAMPLE_EN
          acc_next   = '0;
          round_next = '0;
`endif
        end
      end
      POWER_UP: begin
        if (cnt == SETTLE_C) begin
          state_next = SAMPLE;
          cnt_next   = ONE;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      SAMPLE: begin
        if (cnt == READ_C) begin
          state_next = CONVERT;
          cnt_next   = ONE;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      CONVERT: begin
        // cnt == 1 marks the trigger cycle, where a stale completion flag is ignored
        if (cnt != ONE && adc_conversion_complete) begin
`ifdef SENSOR_ADC_SEQ_OVERSAMPLE_EN
          acc_next = sum;
          if (round == 2'd3) begin
            result_next = sum[17:2];
            done_next   = 1'b1;
            state_next  = IDLE;
            cnt_next    = '0;
          end else begin
            round_next = round + 2'd1;
            state_next = SAMPLE;
            cnt_next   = ONE;
          end
`else
          result_next = adc_value;
          done_next   = 1'b1;
          state_next  = IDLE;
          cnt_next    = '0;
`endif
        end else if (cnt == TIMEOUT_C) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    if (abort && state != IDLE) begin
      state_next   = IDLE;
      cnt_next     = '0;
      result_next  = result;
      done_next    = 1'b0;
      timeout_next = 1'b0;
    end
  end

  // Pin outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      result      <= '0;
      sens_config <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
      sens_enable <= 1'b0;
      adc_enable  <= 1'b0;
      sens_read   <= 1'b0;
      adc_read    <= 1'b0;
`ifdef SENSOR_ADC_SEQ_OVERSAMPLE_EN
      acc         <= '0;
      round       <= '0;
`endif
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      result      <= result_next;
      sens_config <= config_next;
      done        <= done_next;
      timeout     <= timeout_next;
      busy        <= (state_next != IDLE);
      sens_enable <= (state_next != IDLE);
      adc_enable  <= (state_next != IDLE);
      sens_read   <= (state_next == SAMPLE);
      adc_read    <= (state == SAMPLE) && (state_next == CONVERT);
`ifdef SENSOR_ADC_SEQ_OVERSAMPLE_EN
      acc         <= acc_next;
      round       <= round_next;
`endif
    end
  end

endmodule

// File: tb/tb_sensor_adc_sequencer.sv
// Randomised measurement runs checked cycle-by-cycle against a schedule built from the timing rules.
// Define SENSOR_ADC_SEQ_OVERSAMPLE_EN here too when the RTL is built with oversampling.
module tb_sensor_adc_sequencer;
  localparam int S = 8;
  localparam int R = 2;
  localparam int TO = 16;
  localparam int MAXC = 160;
`ifdef SENSOR_ADC_SEQ_OVERSAMPLE_EN
  localparam int ROUNDS = 4;
`else
  localparam int ROUNDS = 1;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic [2:0] config_in = '0;
  logic busy, done, timeout, sens_enable, sens_read, adc_enable, adc_read;
  logic [15:0] result;
  logic [2:0] sens_config;
  logic adc_conversion_complete = 1'b0;
  logic [15:0] adc_value = '0;

  sensor_adc_sequencer #(.SETTLE_TICKS(S), .READ_TICKS(R), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .config_in(config_in),
    .busy(busy), .done(done), .timeout(timeout), .result(result), .sens_config(sens_config),
    .sens_enable(sens_enable), .sens_read(sens_read), .adc_enable(adc_enable), .adc_read(adc_read),
    .adc_conversion_complete(adc_conversion_complete), .adc_value(adc_value)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, meas = 0;
  int dly [4];
  logic [15:0] vals [4];
  bit e_busy [MAXC], e_en [MAXC], e_srd [MAXC], e_ard [MAXC], e_done [MAXC], e_to [MAXC], cmp_at [MAXC];
  logic [15:0] val_at [MAXC];
  int last_c, done_c;
  logic [15:0] exp_result = '0, new_result;
  logic [2:0] exp_cfg = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle pin activity, cycle 1 = first cycle after start is sampled.
  task automatic build(input int abort_at);
    int c, cs;
    bit ended;
    logic [17:0] sum;
    for (int i = 0; i < MAXC; i++) begin
      e_busy[i] = 0; e_en[i] = 0; e_srd[i] = 0; e_ard[i] = 0;
      e_done[i] = 0; e_to[i] = 0; cmp_at[i] = 0; val_at[i] = '0;
    end
    c = 1; ended = 0; sum = '0; done_c = 0;
    for (int i = 0; i < S; i++) begin e_busy[c] = 1; e_en[c] = 1; c++; end
    for (int r = 0; r < ROUNDS; r++) begin
      if (!ended) begin
        for (int i = 0; i < R; i++) begin e_busy[c] = 1; e_en[c] = 1; e_srd[c] = 1; c++; end
        cs = c;
        e_ard[cs] = 1;
        if (dly[r] >= 1 && dly[r] <= TO - 1) begin
          cmp_at[cs + dly[r]] = 1;
          val_at[cs + dly[r]] = vals[r];
          sum = sum + 18'(vals[r]);
          for (int k = 0; k <= dly[r]; k++) begin e_busy[c] = 1; e_en[c] = 1; c++; end
        end else begin
          if (dly[r] == 0) cmp_at[cs] = 1;
          for (int k = 0; k < TO; k++) begin e_busy[c] = 1; e_en[c] = 1; c++; end
          e_to[c] = 1;
          ended = 1;
        end
      end
    end
    new_result = (ROUNDS == 1) ? vals[0] : sum[17:2];
    if (!ended) begin e_done[c] = 1; done_c = c; end
    last_c = c;
    if (abort_at > 0 && abort_at < last_c) begin
      for (int k = abort_at + 1; k <= last_c; k++) begin
        e_busy[k] = 0; e_en[k] = 0; e_srd[k] = 0; e_ard[k] = 0; e_done[k] = 0; e_to[k] = 0;
      end
      done_c = 0;
      last_c = abort_at + 1;
    end
  endtask

  task automatic run(input logic [2:0] cfg, input int abort_at, input int extra_start_at);
    logic [15:0] res_before;
    build(abort_at);
    res_before = exp_result;
    exp_cfg = cfg;
    config_in = cfg;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= last_c + 2; c++) begin
      if (done_c != 0 && c >= done_c) exp_result = new_result;
      check($sformatf("m%0d c%0d busy", meas, c), 32'(busy), 32'(e_busy[c]));
      check($sformatf("m%0d c%0d sens_enable", meas, c), 32'(sens_enable), 32'(e_en[c]));
      check($sformatf("m%0d c%0d adc_enable", meas, c), 32'(adc_enable), 32'(e_en[c]));
      check($sformatf("m%0d c%0d sens_read", meas, c), 32'(sens_read), 32'(e_srd[c]));
      check($sformatf("m%0d c%0d adc_read", meas, c), 32'(adc_read), 32'(e_ard[c]));
      check($sformatf("m%0d c%0d done", meas, c), 32'(done), 32'(e_done[c]));
      check($sformatf("m%0d c%0d timeout", meas, c), 32'(timeout), 32'(e_to[c]));
      check($sformatf("m%0d c%0d result", meas, c), 32'(result), 32'(exp_result));
      check($sformatf("m%0d c%0d sens_config", meas, c), 32'(sens_config), 32'(exp_cfg));
      start = (c == extra_start_at);
      config_in = 3'($urandom);
      abort = (c == abort_at);
      adc_conversion_complete = cmp_at[c];
      adc_value = cmp_at[c] ? val_at[c] : 16'($urandom);
      step();
    end
    start = 1'b0; abort = 1'b0; adc_conversion_complete = 1'b0;
    $display("meas %0d cfg=%0d abort_at=%0d end=%0d result=%h (was %h)",
             meas, cfg, abort_at, last_c, result, res_before);
    meas++;
  endtask

  initial begin
    // reset state
    repeat (3) step();
    check("reset busy", 32'(busy), 32'd0);
    check("reset pins", 32'({sens_enable, sens_read, adc_enable, adc_read, done, timeout}), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset sens_config", 32'(sens_config), 32'd0);
    #3 rst_n = 1'b1;
    step();

    // nominal measurement with a second start ignored at cycle 3
    for (int r = 0; r < 4; r++) dly[r] = 3;
`ifdef SENSOR_ADC_SEQ_OVERSAMPLE_EN
    vals[0] = 16'd100; vals[1] = 16'd101; vals[2] = 16'd102; vals[3] = 16'd104;
`else
    vals[0] = 16'hBEEF; vals[1] = '0; vals[2] = '0; vals[3] = '0;
`endif
    run(3'b101, 0, 3);

    // no completion at all -> timeout, result kept
    dly[0] = -1; dly[1] = 2; dly[2] = 2; dly[3] = 2;
    run(3'b011, 0, 0);

    // completion only on the trigger cycle -> ignored, timeout
    dly[0] = 0;
    run(3'b001, 0, 0);

    // abort during power-up
    for (int r = 0; r < 4; r++) begin dly[r] = 4; vals[r] = 16'h1234; end
    run(3'b111, 5, 0);

    // start and abort together in idle
    config_in = 3'b010; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start+abort busy", 32'(busy), 32'd0);
    check("start+abort sens_enable", 32'(sens_enable), 32'd0);
    check("start+abort sens_config", 32'(sens_config), 32'(exp_cfg));
    step();
    check("start+abort busy later", 32'(busy), 32'd0);
    $display("start+abort in idle: busy=%0d sens_config=%0d", busy, sens_config);

    // asynchronous reset in the middle of SAMPLE
    config_in = 3'b110; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < S + 1; c++) step();
    check("pre-reset sens_read", 32'(sens_read), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset pins", 32'({sens_enable, sens_read, adc_enable, adc_read, done, timeout}), 32'd0);
    check("async reset result", 32'(result), 32'd0);
    check("async reset sens_config", 32'(sens_config), 32'd0);
    $display("async reset mid-sample: busy=%0d sens_read=%0d result=%h", busy, sens_read, result);
    exp_result = '0;
    step();
    rst_n = 1'b1;
    step();

    // randomised measurements
    for (int n = 0; n < 14; n++) begin
      for (int r = 0; r < 4; r++) begin
        vals[r] = 16'($urandom);
        dly[r] = ($urandom_range(0, 99) < 12) ? -1 : int'($urandom_range(1, TO - 1));
      end
      run(3'($urandom), ($urandom_range(0, 99) < 15) ? int'($urandom_range(1, 20)) : 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
